// File: rtl/somma_pkg.sv
// somma_pkg: shared types and helpers for the serial adder/subtractor.
//   state_t     - FSM state encoding (IDLE, BUSY)
//   cnt_width() - digit-counter width for N = WIDTH/DIGIT cycles (at least 1 bit)
package somma_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/somma_seriale_if.sv
// somma_seriale_if: start/done handshake bundle of the serial adder.
//   start, sub, a, b          - request side (driven by master)
//   busy, done, sum, cout, ovf - status/result side (driven by slave)
interface somma_seriale_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/somma_cifra.sv
// somma_cifra: combinational DIGIT-bit ripple-carry slice.
//   x, y  - DIGIT-bit operand digits
//   cin   - carry in
//   s     - DIGIT-bit sum digit
//   cout  - carry out of the slice MSB
//   c_msb - carry into the slice MSB (used for signed overflow)
module somma_cifra #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/somma_seriale.sv
// somma_seriale: multi-cycle adder/subtractor, DIGIT bits per clock, LSB first.
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - somma_seriale_if.slave: start/sub/a/b in; busy/done/sum/cout/ovf out
// Parameters: WIDTH (multiple of DIGIT), DIGIT. One operation takes N = WIDTH/DIGIT
// busy cycles; done pulses for one cycle once sum/cout/ovf have been updated.
// Optional macro SOMMA_SAT_EN: on signed overflow, sum saturates to the signed
// limit selected by the MSB of operand A.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   BUSY  | one digit per clock, cnt counts processed digits
module somma_seriale
  import somma_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  somma_seriale_if.slave bus
);

  localparam int            N    = WIDTH / DIGIT;
  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic [DIGIT-1:0] s_dig;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_fin;

  somma_cifra #(.DIGIT(DIGIT)) u_cifra (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .s    (s_dig),
    .cout (c_out),
    .c_msb(c_msb)
  );

  // New digit enters at the top; after N shifts the result is aligned.
  assign res_next = (res >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));

`ifdef SOMMA_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // On the final digit a_sh[DIGIT-1] is the original MSB of A.
  always_comb begin
    sum_fin = res_next;
    if (c_msb ^ c_out)
      sum_fin = a_sh[DIGIT-1] ? SAT_NEG : SAT_POS;
  end
`else
  assign sum_fin = res_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            res   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          res   <= res_next;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= c_out;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt    <= '0;
            state  <= IDLE;
            sum_q  <= sum_fin;
            cout_q <= c_out;
            ovf_q  <= c_msb ^ c_out;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == BUSY);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
